// File: rtl/reset_sequencer.sv
// Board reset/boot controller: synchronises and debounces inputs, releases
// domain resets in staggered order and requests the bootloader on a long press.
module reset_sequencer #(
    parameter int NUM_DOMAINS      = 3,
    parameter int DEBOUNCE_CYCLES  = 48000,
    parameter int STAGGER_CYCLES   = 16,
    parameter int BOOT_HOLD_CYCLES = 96000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pll_locked,
    input  logic                   hold_n,
    input  logic                   btn_n,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   ready,
    output logic                   bootloader_n
);

    localparam logic [2:0] HOLD    = 3'd0;
    localparam logic [2:0] STAGGER = 3'd1;
    localparam logic [2:0] RUN     = 3'd2;
    localparam logic [2:0] PRESS   = 3'd3;
    localparam logic [2:0] BOOT    = 3'd4;

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int STAG_TOP = NUM_DOMAINS * STAGGER_CYCLES;
    localparam int CNT_TOP = (STAG_TOP > BOOT_HOLD_CYCLES) ? STAG_TOP : BOOT_HOLD_CYCLES;
    localparam int CW = $clog2(CNT_TOP + 1);

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] STAG_END = CW'(STAG_TOP);
    localparam logic [CW-1:0] BOOT_END = CW'(BOOT_HOLD_CYCLES);

    logic [1:0] pll_sync_q;
    logic [1:0] hold_sync_q;
    logic [1:0] btn_sync_q;

    // Reset leaves the PLL/hold paths "not ok" and the button "released"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_sync_q  <= 2'b00;
            hold_sync_q <= 2'b00;
            btn_sync_q  <= 2'b11;
        end else begin
            pll_sync_q  <= {pll_sync_q[0], pll_locked};
            hold_sync_q <= {hold_sync_q[0], hold_n};
            btn_sync_q  <= {btn_sync_q[0], btn_n};
        end
    end

    logic ok;
    logic btn_s;

    assign ok    = pll_sync_q[1] & hold_sync_q[1];
    assign btn_s = btn_sync_q[1];

    logic [DW-1:0] db_cnt_q;
    logic [DW-1:0] db_cnt_d;
    logic          btn_db_q;
    logic          btn_db_d;

    always_comb begin
        db_cnt_d = db_cnt_q;
        btn_db_d = btn_db_q;
        if (btn_s == btn_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            btn_db_d = btn_s;
            db_cnt_d = '0;
        end else if (db_cnt_q != '1) begin
            db_cnt_d = db_cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
            btn_db_q <= 1'b1;
        end else begin
            db_cnt_q <= db_cnt_d;
            btn_db_q <= btn_db_d;
        end
    end

    logic pressed;
    assign pressed = ~btn_db_q;

    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            HOLD: begin
                cnt_d = '0;
                if (ok && !pressed) state_d = STAGGER;
            end
            STAGGER: begin
                if (!ok) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == STAG_END) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!ok) state_d = HOLD;
                else if (pressed) state_d = PRESS;
            end
            PRESS: begin
                if (!ok || !pressed) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == BOOT_END) state_d = BOOT;
                end
            end
            BOOT: begin
                state_d = BOOT;
            end
            default: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HOLD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are registered from the next state so they never glitch
    logic [NUM_DOMAINS-1:0] domain_rst_d;
    logic [NUM_DOMAINS-1:0] domain_rst_q;
    logic                   ready_q;
    logic                   boot_n_q;

    always_comb begin
        domain_rst_d = '1;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (state_d == RUN)
                domain_rst_d[i] = 1'b0;
            else if (state_d == STAGGER &&
                     cnt_d >= CW'((i + 1) * STAGGER_CYCLES))
                domain_rst_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            domain_rst_q <= '1;
            ready_q      <= 1'b0;
            boot_n_q     <= 1'b1;
        end else begin
            domain_rst_q <= domain_rst_d;
            ready_q      <= (state_d == RUN);
            boot_n_q     <= (state_d != BOOT);
        end
    end

    assign domain_rst   = domain_rst_q;
    assign ready        = ready_q;
    assign bootloader_n = boot_n_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomised bench for reset_sequencer against a cycle-level
// behavioural model of the boot controller.
module tb_reset_sequencer;

    localparam int N   = 3;
    localparam int DEB = 4;
    localparam int STG = 3;
    localparam int BH  = 20;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pll_locked;
    logic         hold_n;
    logic         btn_n;
    logic [N-1:0] domain_rst;
    logic         ready;
    logic         bootloader_n;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    reset_sequencer #(
        .NUM_DOMAINS(N),
        .DEBOUNCE_CYCLES(DEB),
        .STAGGER_CYCLES(STG),
        .BOOT_HOLD_CYCLES(BH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pll_locked(pll_locked),
        .hold_n(hold_n),
        .btn_n(btn_n),
        .domain_rst(domain_rst),
        .ready(ready),
        .bootloader_n(bootloader_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: mode 0 hold, 1 stagger, 2 run, 3 press, 4 boot
    int       m_mode;
    int       m_el;
    int       m_run;
    logic [1:0] m_p, m_h, m_b;
    logic       m_db;
    logic [N-1:0] exp_rst;
    logic         exp_ready;
    logic         exp_boot;

    always @(posedge clk or negedge rst_n) begin
        bit ok;
        if (!rst_n) begin
            m_mode = 0;
            m_el = 0;
            m_run = 0;
            m_p = 2'b00;
            m_h = 2'b00;
            m_b = 2'b11;
            m_db = 1'b1;
        end else begin
            ok = m_p[1] && m_h[1];
            case (m_mode)
                0: if (ok && m_db) begin m_mode = 1; m_el = 0; end
                1: if (!ok) m_mode = 0;
                   else if (m_el == N * STG) m_mode = 2;
                   else m_el++;
                2: if (!ok) m_mode = 0;
                   else if (!m_db) begin m_mode = 3; m_el = 0; end
                3: if (!ok || m_db) m_mode = 0;
                   else begin
                       m_el++;
                       if (m_el == BH) m_mode = 4;
                   end
                default: m_mode = 4;
            endcase
            if (m_b[1] != m_db) begin
                m_run++;
                if (m_run == DEB) begin
                    m_db = m_b[1];
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_p = {m_p[0], pll_locked};
            m_h = {m_h[0], hold_n};
            m_b = {m_b[0], btn_n};
        end
        for (int i = 0; i < N; i++)
            exp_rst[i] = !(m_mode == 2 || (m_mode == 1 && m_el >= (i + 1) * STG));
        exp_ready = (m_mode == 2);
        exp_boot  = (m_mode != 4);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("domain_rst", domain_rst, exp_rst);
            chk("ready", ready, exp_ready);
            chk("bootloader_n", bootloader_n, exp_boot);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_110(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick(1);
            if (domain_rst == 3'b110) seen = 1'b1;
        end
        chk(tag, seen, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        pll_locked = 1'b0;
        hold_n = 1'b0;
        btn_n = 1'b1;
        chk_en = 1'b1;
        tick(3);
        chk("rst_dom", domain_rst, 3'b111);
        chk("rst_ready", ready, 0);
        chk("rst_boot", bootloader_n, 1);

        rst_n = 1'b1;
        pll_locked = 1'b1;
        hold_n = 1'b1;
        tick(20);
        chk("t1_ready", ready, 1);
        chk("t1_dom", domain_rst, 3'b000);

        btn_n = 1'b0;
        tick(3);
        btn_n = 1'b1;
        tick(10);
        chk("t2_dom", domain_rst, 3'b000);

        btn_n = 1'b0;
        tick(10);
        chk("t3_held", domain_rst, 3'b111);
        btn_n = 1'b1;
        tick(25);
        chk("t3_ready", ready, 1);

        pll_locked = 1'b0;
        tick(2);
        pll_locked = 1'b1;
        wait_110("t5_seen110");
        pll_locked = 1'b0;
        tick(4);
        chk("t5_dom", domain_rst, 3'b111);
        pll_locked = 1'b1;
        tick(20);
        chk("t5_ready", ready, 1);

        btn_n = 1'b0;
        tick(30);
        btn_n = 1'b1;
        tick(5);
        pll_locked = 1'b0;
        tick(5);
        chk("t4_boot", bootloader_n, 0);
        chk("t4_dom", domain_rst, 3'b111);
        pll_locked = 1'b1;

        rst_n = 1'b0;
        tick(2);
        chk("t4_restore", bootloader_n, 1);
        rst_n = 1'b1;
        tick(20);
        btn_n = 1'b0;
        tick(12);
        chk("t6_press", domain_rst, 3'b111);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_dom", domain_rst, 3'b111);
        chk("t6_ready", ready, 0);
        chk("t6_boot", bootloader_n, 1);
        tick(2);
        btn_n = 1'b1;
        rst_n = 1'b1;
        tick(20);

        for (int r = 0; r < 40; r++) begin
            if (!exp_boot) begin
                rst_n = 1'b0;
                tick(2);
                rst_n = 1'b1;
            end
            case ($urandom_range(0, 3))
                0: pll_locked = 1'b0;
                1: hold_n = 1'b0;
                default: btn_n = 1'b0;
            endcase
            tick($urandom_range(1, 26));
            pll_locked = 1'b1;
            hold_n = 1'b1;
            btn_n = 1'b1;
            tick($urandom_range(1, 30));
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
